// File: rtl/uart_rx_word_packer_if.sv
// Byte-in / word-out bundle for the UART RX word packer.
// The master side feeds bytes and consumes words; the slave side is the packer itself.
interface uart_rx_word_packer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          en;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          word_valid;
  logic [31:0]   word_data;
  logic          word_ready;
  logic [CW-1:0] word_count;
  logic          ovf_clr;
  logic          overflow;
  logic          timeout;

  modport master (
    output en, rx_valid, rx_data, word_ready, ovf_clr,
    input  word_valid, word_data, word_count, overflow, timeout
  );

  modport slave (
    input  en, rx_valid, rx_data, word_ready, ovf_clr,
    output word_valid, word_data, word_count, overflow, timeout
  );
endinterface

// File: rtl/uart_rx_word_packer.sv
// Packs received UART bytes into 32-bit little-endian words and buffers them in a
// first-word-fall-through FIFO; partial words are dropped on an inter-byte timeout.
module uart_rx_word_packer #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic                 sys_clk,
  input logic                 sys_rst,
  uart_rx_word_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [15:0]   TIMER_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [23:0] shift, shift_nxt;
  logic [15:0] timer, timer_nxt;
  logic        timeout_q, timeout_nxt;
  logic        push;
  logic [31:0] push_word;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   last_pop;
  logic          overflow_q;
  logic          full, do_pop, do_push, drop;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      shift     <= '0;
      timer     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      shift     <= shift_nxt;
      timer     <= timer_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // The timer only runs while a word is partially collected; a byte on the expiry cycle wins.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    shift_nxt    = shift;
    timer_nxt    = '0;
    timeout_nxt  = 1'b0;
    push         = 1'b0;
    push_word    = {bus.rx_data, shift};
    if (!bus.en) begin
      state_nxt    = IDLE;
      byte_cnt_nxt = '0;
    end else if (bus.rx_valid) begin
      if (byte_cnt == 2'd3) begin
        push         = 1'b1;
        state_nxt    = IDLE;
        byte_cnt_nxt = '0;
      end else begin
        state_nxt    = COLLECT;
        byte_cnt_nxt = byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    shift_nxt[7:0]   = bus.rx_data;
          2'd1:    shift_nxt[15:8]  = bus.rx_data;
          default: shift_nxt[23:16] = bus.rx_data;
        endcase
      end
    end else if (state == COLLECT) begin
      if (timer == TIMER_LAST) begin
        state_nxt    = IDLE;
        byte_cnt_nxt = '0;
        timeout_nxt  = 1'b1;
      end else begin
        timer_nxt = timer + 16'd1;
      end
    end
  end

  // A push into a full FIFO still lands when a pop frees the head slot in the same cycle.
  assign full    = (count == FULL_CNT);
  assign do_pop  = bus.word_valid & bus.word_ready;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst && do_push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_pop   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        last_pop <= mem[rd_ptr];
      end
      count <= count + CW'(do_push) - CW'(do_pop);
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // When empty, the head shows the most recently popped word rather than stale storage.
  assign bus.word_valid = (count != '0);
  assign bus.word_data  = bus.word_valid ? mem[rd_ptr] : last_pop;
  assign bus.word_count = count;
  assign bus.overflow   = overflow_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Testbench for uart_rx_word_packer: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a queue-based reference model.
module tb_uart_rx_word_packer;
  localparam int DEPTH = 8;
  localparam int TCYC  = 100;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  uart_rx_word_packer_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_word_packer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TCYC)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  logic [31:0] exp_q [$];
  logic [7:0]  part [$];
  int          gap;
  logic        exp_ovf;
  logic [31:0] exp_last;
  logic        exp_to;
  logic [31:0] got_q [$];
  int          to_seen;
  int          errors;
  int          checks;
  logic [31:0] words [10];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] gotAt(input int i);
    if (i < got_q.size()) return got_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive inputs, advance the model, then compare all outputs after the edge.
  task automatic applyStimulus(input logic rst, input logic en, input logic rv,
                               input logic [7:0] d, input logic rdy, input logic clr);
    logic        pop, push, full, dropw;
    logic [31:0] w;
    sys_rst        = rst;
    bus.en         = en;
    bus.rx_valid   = rv;
    bus.rx_data    = d;
    bus.word_ready = rdy;
    bus.ovf_clr    = clr;
    if (!rst && bus.word_valid && rdy) got_q.push_back(bus.word_data);
    push   = 1'b0;
    dropw  = 1'b0;
    exp_to = 1'b0;
    w      = '0;
    if (rst) begin
      exp_q.delete();
      part.delete();
      gap      = 0;
      exp_ovf  = 1'b0;
      exp_last = '0;
    end else begin
      pop  = (exp_q.size() > 0) && rdy;
      full = (exp_q.size() == DEPTH);
      if (!en) begin
        part.delete();
        gap = 0;
      end else if (rv) begin
        part.push_back(d);
        gap = 0;
        if (part.size() == 4) begin
          w    = {part[3], part[2], part[1], part[0]};
          push = 1'b1;
          part.delete();
        end
      end else if (part.size() > 0) begin
        gap++;
        if (gap == TCYC) begin
          part.delete();
          gap    = 0;
          exp_to = 1'b1;
        end
      end
      if (pop) exp_last = exp_q.pop_front();
      if (push) begin
        if (!full || pop) exp_q.push_back(w);
        else dropw = 1'b1;
      end
      if (dropw) exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
    end
    @(posedge sys_clk);
    #1;
    if (bus.timeout) to_seen++;
    checkOutput("word_valid", 32'(bus.word_valid), 32'(exp_q.size() > 0));
    checkOutput("word_count", 32'(bus.word_count), 32'(exp_q.size()));
    checkOutput("word_data", bus.word_data, (exp_q.size() > 0) ? exp_q[0] : exp_last);
    checkOutput("overflow", 32'(bus.overflow), 32'(exp_ovf));
    checkOutput("timeout", 32'(bus.timeout), 32'(exp_to));
  endtask

  task automatic sendByte(input logic [7:0] b, input logic rdy);
    applyStimulus(1'b0, 1'b1, 1'b1, b, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic sendWord(input logic [31:0] w, input logic rdy);
    for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8], rdy);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    to_seen = 0;
    gap     = 0;
    exp_ovf = 1'b0;
    exp_last = '0;
    exp_to  = 1'b0;
    bus.en = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0; bus.word_ready = 1'b0; bus.ovf_clr = 1'b0;

    doReset();
    doReset();
    checkOutput("rst_valid", 32'(bus.word_valid), 32'd0);
    checkOutput("rst_data", bus.word_data, 32'd0);

    // Single spaced-out word
    got_q.delete();
    sendByte(8'h11, 1'b1); idle(9, 1'b1);
    sendByte(8'h22, 1'b1); idle(9, 1'b1);
    sendByte(8'h33, 1'b1); idle(9, 1'b1);
    sendByte(8'h44, 1'b1); idle(3, 1'b1);
    checkOutput("t1_nwords", 32'(got_q.size()), 32'd1);
    checkOutput("t1_word", gotAt(0), 32'h4433_2211);
    checkOutput("t1_count", 32'(bus.word_count), 32'd0);

    // Timeout drops a partial word
    got_q.delete(); to_seen = 0;
    sendByte(8'hAA, 1'b1); sendByte(8'hBB, 1'b1);
    idle(150, 1'b1);
    sendWord(32'h0403_0201, 1'b1);
    idle(3, 1'b1);
    checkOutput("t2_pulses", 32'(to_seen), 32'd1);
    checkOutput("t2_nwords", 32'(got_q.size()), 32'd1);
    checkOutput("t2_word", gotAt(0), 32'h0403_0201);

    // Overflow with ready low, then clear and drain in order
    got_q.delete();
    for (int i = 0; i < 9; i++) begin
      words[i] = $urandom;
      sendWord(words[i], 1'b0);
    end
    idle(2, 1'b0);
    checkOutput("t3_count", 32'(bus.word_count), 32'd8);
    checkOutput("t3_ovf", 32'(bus.overflow), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t3_ovf_clr", 32'(bus.overflow), 32'd0);
    idle(DEPTH + 2, 1'b1);
    checkOutput("t3_nwords", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) checkOutput("t3_order", gotAt(i), words[i]);

    // Full FIFO, last byte of a new word coincides with a pop
    got_q.delete();
    for (int i = 0; i < 9; i++) words[i] = $urandom;
    for (int i = 0; i < 8; i++) sendWord(words[i], 1'b0);
    for (int k = 0; k < 3; k++) sendByte(words[8][8*k +: 8], 1'b0);
    sendByte(words[8][31:24], 1'b1);
    checkOutput("t4_count", 32'(bus.word_count), 32'd8);
    checkOutput("t4_ovf", 32'(bus.overflow), 32'd0);
    idle(DEPTH + 2, 1'b1);
    checkOutput("t4_nwords", 32'(got_q.size()), 32'd9);
    checkOutput("t4_last", gotAt(8), words[8]);

    // Byte exactly on the expiry cycle, then en dropped mid-word
    got_q.delete(); to_seen = 0;
    sendByte(8'hC1, 1'b1); sendByte(8'hC2, 1'b1);
    idle(TCYC - 1, 1'b1);
    sendByte(8'hC3, 1'b1); sendByte(8'hC4, 1'b1);
    idle(3, 1'b1);
    checkOutput("t5_pulses", 32'(to_seen), 32'd0);
    checkOutput("t5_word", gotAt(0), 32'hC4C3_C2C1);
    sendByte(8'hE1, 1'b1); sendByte(8'hE2, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h78, 1'b1, 1'b0);
    sendWord(32'hD4D3_D2D1, 1'b1);
    idle(TCYC + 5, 1'b1);
    checkOutput("t5_nwords", 32'(got_q.size()), 32'd2);
    checkOutput("t5_en_word", gotAt(1), 32'hD4D3_D2D1);
    checkOutput("t5_no_pulse", 32'(to_seen), 32'd0);

    // Reset with words queued and a partial word pending
    for (int i = 0; i < 3; i++) sendWord($urandom, 1'b0);
    sendByte(8'h5A, 1'b0); sendByte(8'h5B, 1'b0);
    doReset();
    checkOutput("t6_valid", 32'(bus.word_valid), 32'd0);
    checkOutput("t6_data", bus.word_data, 32'd0);
    checkOutput("t6_count", 32'(bus.word_count), 32'd0);
    checkOutput("t6_ovf", 32'(bus.overflow), 32'd0);
    got_q.delete();
    sendWord(32'h8765_4321, 1'b0);
    idle(3, 1'b1);
    checkOutput("t6_nwords", 32'(got_q.size()), 32'd1);
    checkOutput("t6_word", gotAt(0), 32'h8765_4321);

    // Randomized traffic with varying byte density, backpressure and occasional resets
    for (int seg = 0; seg < 8; seg++) begin
      int rx_pct, rdy_pct;
      rx_pct  = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 40 : 2);
      rdy_pct = (seg % 2 == 0) ? 60 : 10;
      for (int c = 0; c < 500; c++) begin
        applyStimulus($urandom_range(999) == 0,
                      $urandom_range(99) >= 3,
                      $urandom_range(99) < rx_pct,
                      8'($urandom),
                      $urandom_range(99) < rdy_pct,
                      $urandom_range(99) < 2);
      end
    end
    idle(DEPTH + TCYC + 4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
